zjh_pipe_adder: RTL and testbench
=================================

# zjh_pipe_adder

Parametrised, pipelined binary adder/subtractor that generalises the team's 4-bit 74HC283-style ripple adder to arbitrary width. The carry chain is cut into SEG-bit segments with one register stage per segment. This keeps per-cycle logic depth fixed while sustaining one operation per clock. Sits between operand producers and result consumers on a valid/ready stream and adds subtract mode, signed-overflow detection and backpressure.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits added per pipeline stage; STAGES = WIDTH/SEG, at least 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow.
- busy  out  1  any pipeline stage holds a valid beat.

## Operation
- Add: sum = a + b + cin, mod 2^WIDTH.
- Subtract: sum = a + ~b + !cin, which equals a − b − cin.
- cout is the raw carry out of bit WIDTH−1.
- ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Stage k (0 = LSB segment) adds segment k of A and effective B with the carry registered from stage k−1.
  - Stage 0 uses cin ^ sub as its carry-in.
- Upper, not-yet-added segments of A and B travel forward with the beat (skew).
- Completed lower result segments travel forward to the last stage (deskew).
- The last stage register drives sum/cout/ovf/out_valid directly. There is no combinational path from a, b or cin to the outputs.
- Each stage has its own valid bit. Stage k loads when it is empty or stage k+1 (or the consumer, for the last stage) takes its beat this cycle.
- in_ready = stage-0 load condition. It may depend combinationally on out_ready.
- Beats leave in acceptance order. There is no loss, duplication or reordering.
- busy = OR of all stage valid bits.

## Timing
- Reset (asynchronous assert, synchronous release by clk): all valid bits = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0, busy = 0.
- After reset release, in_ready = 1.
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+STAGES−1, i.e. STAGES cycles of pipeline, 4 for the defaults.
- Throughput: 1 beat/cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, sum/cout/ovf hold stable.
  - Stages fill up from the output end.
  - in_ready drops when all STAGES stages are valid and out_ready = 0.
- Simultaneous accept and release on a full pipe is permitted: with out_ready = 1, in_ready = 1 even when full.
- Reset mid-operation discards all in-flight beats. No output is produced for them.
- STAGES = 1 degenerates to a single registered adder with the same handshake.
- in_valid asserted with in_ready = 0: the beat is held by the producer (stream rule). a/b/cin/sub are sampled only when in_valid && in_ready.

## Structure
- Shared package zjh_arith_pkg:
  - function for STAGES and a parameter-check function (WIDTH % SEG == 0).
  - typedef of the stage record: valid, carry, A/B remainder, partial sum.
- Sub-module zjh_seg_adder: combinational SEG-bit ripple adder.
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb, the carry into its MSB, used for ovf.
  - Instantiated once per stage via generate.

## Test plan
- WIDTH=16, SEG=4: a=0x1234, b=0x0FFF, cin=0, sub=0 -> sum=0x2233, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0. This checks carry through all 4 stages.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1.
- a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- Stream 8 random beats back-to-back, hold out_ready=0 for cycles 3–6:
  - in_ready drops once 4 beats are held.
  - Outputs are stable while stalled.
  - All 8 results are correct and in order vs. the reference model.
- Pulse rst_n low for one cycle with 3 beats in flight -> out_valid, busy and sum go to 0 immediately, no stale beat emerges, and the next accepted beat completes with 4-cycle latency. Repeat the first scenario with WIDTH=8, SEG=8 (1 stage).

Source files
------------

// File: rtl/zjh_arith_pkg.sv
// Shared helpers and types for the zjh pipelined adder family: stage-count
// math, a parameter sanity check and the per-stage control record.
package zjh_arith_pkg;

    function automatic int unsigned calc_stages(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned seg);
        return (seg != 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

    // Control half of a stage record; the data half depends on WIDTH and is
    // completed inside the adder that knows its width.
    typedef struct packed {
        logic valid;  // stage holds a live beat
        logic carry;  // carry out of the most recently added segment
        logic c_msb;  // carry into the MSB of that segment (overflow source)
    } stage_ctl_t;

endpackage

// File: rtl/zjh_seg_adder.sv
// Combinational SEG-bit ripple adder, one per pipeline stage. Besides the
// carry out it exposes the carry into its MSB so the top can form overflow.
module zjh_seg_adder #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG:0] c;

    always_comb begin
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/zjh_pipe_adder.sv
// Pipelined add/subtract on a valid/ready stream: the carry chain is cut into
// SEG-bit segments with one register stage per segment and per-stage valids.
module zjh_pipe_adder
    import zjh_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned STAGES = calc_stages(WIDTH, SEG);

    if (!params_ok(WIDTH, SEG)) begin : g_param_check
        $error("zjh_pipe_adder: WIDTH must be a non-zero multiple of SEG");
    end

    // a_rem/b_rem carry the not-yet-added upper segments forward (skew);
    // psum collects finished lower segments on their way to the output (deskew).
    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] psum;
    } stage_t;

    stage_t            stage_q [STAGES];
    stage_t            stage_d [STAGES];
    stage_t            src     [STAGES];
    stage_t            src_in;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] load;
    logic [SEG-1:0]    seg_s   [STAGES];
    logic [STAGES-1:0] seg_co;
    logic [STAGES-1:0] seg_cm;

    // Subtract is a + ~b + !cin, so stage 0 sees the inverted B and cin ^ sub.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        src_in           = '0;
        src_in.ctl.valid = in_valid;
        src_in.ctl.carry = cin ^ sub;
        src_in.a_rem     = a;
        src_in.b_rem     = sub ? ~b : b;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src[k] = src_in;
        end else begin : g_body
            assign src[k] = stage_q[k-1];
        end

        assign vld[k] = stage_q[k].ctl.valid;

        zjh_seg_adder #(.SEG(SEG)) u_seg (
            .a     (src[k].a_rem[k*SEG +: SEG]),
            .b     (src[k].b_rem[k*SEG +: SEG]),
            .ci    (src[k].ctl.carry),
            .s     (seg_s[k]),
            .co    (seg_co[k]),
            .c_msb (seg_cm[k])
        );
    end

    // A stage loads when empty or when its beat is taken downstream this cycle.
    always_comb begin
        load[STAGES-1] = !vld[STAGES-1] || out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            load[k] = !vld[k] || load[k+1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = stage_q[k];
            if (load[k]) begin
                stage_d[k].ctl.valid = src[k].ctl.valid;
                // Data only moves with a live beat, so a bubble leaves sum untouched.
                if (src[k].ctl.valid) begin
                    stage_d[k].a_rem                 = src[k].a_rem;
                    stage_d[k].b_rem                 = src[k].b_rem;
                    stage_d[k].psum                  = src[k].psum;
                    stage_d[k].psum[k*SEG +: SEG]    = seg_s[k];
                    stage_d[k].ctl.carry             = seg_co[k];
                    stage_d[k].ctl.c_msb             = seg_cm[k];
                end
            end
        end
    end

    // Data fields are reset along with the valids because the last stage
    // drives sum/cout/ovf directly and they must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                // NOTE: registers take non-blocking assignments so every stage samples pre-edge values.
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign in_ready  = load[0];
    assign busy      = |vld;
    assign out_valid = stage_q[STAGES-1].ctl.valid;
    assign sum       = stage_q[STAGES-1].psum;
    assign cout      = stage_q[STAGES-1].ctl.carry;
    assign ovf       = stage_q[STAGES-1].ctl.carry ^ stage_q[STAGES-1].ctl.c_msb;

endmodule

// File: tb/tb_zjh_pipe_adder.sv
// Scoreboard bench for zjh_pipe_adder: a 16-bit/4-stage instance and an
// 8-bit/1-stage instance, directed vectors with hand-computed results.
module tb_zjh_pipe_adder;

    localparam int STG = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf, busy;
    logic [15:0] sum;

    logic        in_valid8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready8, out_valid8, cout8, ovf8, busy8;
    logic [7:0]  sum8;

    zjh_pipe_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    zjh_pipe_adder #(.WIDTH(8), .SEG(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp8_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic reference: returns {ovf, cout, sum}.
    function automatic logic [17:0] ref_model(input logic [15:0] ta, input logic [15:0] tb,
                                              input logic tci, input logic tsub);
        logic [15:0] bx;
        logic [16:0] full;
        logic [15:0] low;
        logic        c0;
        bx   = tsub ? ~tb : tb;
        c0   = tci ^ tsub;
        full = {1'b0, ta} + {1'b0, bx} + 17'(c0);
        low  = {1'b0, ta[14:0]} + {1'b0, bx[14:0]} + 16'(c0);
        return {full[16] ^ low[15], full[16], full[15:0]};
    endfunction

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                        input logic tsub, input logic [15:0] es, input logic ec,
                        input logic eo, input bit lat);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        a = ta; b = tb; cin = tci; sub = tsub; in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc + 1; e.lat = lat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                         input logic tsub, input logic [7:0] es, input logic ec,
                         input logic eo);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tci; sub8 = tsub; in_valid8 = 1'b1;
        #1;
        while (!in_ready8 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready8) begin
            check("in_ready8_timeout", 32'(in_ready8), 32'd1);
            in_valid8 = 1'b0;
            return;
        end
        e.sum = 16'(es); e.cout = ec; e.ovf = eo; e.acc = cyc + 1; e.lat = 1'b1;
        exp8_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
    endtask

    // Monitors: pop and compare whenever a result beat is handed over.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: sum 0x%0h emitted with no beat outstanding", sum);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    if (e.lat) check("latency", 32'(cyc - e.acc), 32'(STG - 1));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid8 && out_ready8) begin
                if (exp8_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat8: sum 0x%0h emitted with no beat outstanding", sum8);
                end else begin
                    e = exp8_q.pop_front();
                    check("sum8", 32'(sum8), 32'(e.sum));
                    check("cout8", 32'(cout8), 32'(e.cout));
                    check("ovf8", 32'(ovf8), 32'(e.ovf));
                    check("latency8", 32'(cyc - e.acc), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [15:0] sa [8] = '{16'h0001, 16'hABCD, 16'hFFFF, 16'h8000,
                            16'h7FFF, 16'h0F0F, 16'hDEAD, 16'h1111};
    logic [15:0] sb [8] = '{16'h0002, 16'h1234, 16'hFFFF, 16'h8000,
                            16'h7FFF, 16'hF0F1, 16'hBEEF, 16'h2222};

    initial begin
        logic [17:0] r0;
        int          g;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Directed vectors, back-to-back, latency checked
        send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        send(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
        send(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b1);
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin @(negedge clk); g++; end
        check("drain_directed", 32'(exp_q.size()), 32'd0);

        // Stream of 8 beats with a consumer stall
        r0 = ref_model(sa[0], sb[0], 1'b0, 1'b0);
        fork
            begin
                logic [17:0] r;
                for (int i = 0; i < 8; i++) begin
                    r = ref_model(sa[i], sb[i], 1'b0, 1'b0);
                    send(sa[i], sb[i], 1'b0, 1'b0, r[15:0], r[16], r[17], 1'b0);
                end
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                for (int t = 0; t < 3; t++) begin
                    @(negedge clk);
                    #1;
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_busy", 32'(busy), 32'd1);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    check("stall_sum", 32'(sum), 32'(r0[15:0]));
                    check("stall_cout_ovf", 32'({ovf, cout}), 32'({r0[17], r0[16]}));
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin @(negedge clk); g++; end
        check("drain_stream", 32'(exp_q.size()), 32'd0);

        // Reset with three beats in flight
        send(16'h1111, 16'h1111, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0);
        send(16'h2222, 16'h2222, 1'b0, 1'b0, 16'h4444, 1'b0, 1'b0, 1'b0);
        send(16'h3333, 16'h3333, 1'b0, 1'b0, 16'h6666, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("post_rst_idle_valid", 32'(out_valid), 32'd0);
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1);
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin @(negedge clk); g++; end
        check("drain_post_reset", 32'(exp_q.size()), 32'd0);

        // Single-stage instance
        send8(8'h34, 8'hFF, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0);
        send8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        send8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        g = 0;
        while (exp8_q.size() != 0 && g < 100) begin @(negedge clk); g++; end
        check("drain_8bit", 32'(exp8_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
